// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronises and debounces the 5/10 coin sensors, queues
// accepted coins and issues each one as a single-cycle amt pulse to the vending FSM.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int GAP_CYCLES      = 1,
  localparam int CW             = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          coin5_raw,
  input  logic          coin10_raw,
  input  logic          inhibit,
  output logic [3:0]    amt,
  output logic          coin_reject,
  output logic [CW-1:0] fifo_count
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int GW  = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  // Channel index 0 = 5-unit sensor, 1 = 10-unit sensor.
  logic [1:0]     sync1_q, sync2_q, deb_q, deb_d, deb_prev_q;
  logic [DBW-1:0] cnt_q [2];
  logic [DBW-1:0] cnt_d [2];
  logic [1:0]     rise;
  logic           push_req, push, pop, full, head;

  logic           mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;
  state_t         state_q;
  logic [GW-1:0]  gap_q;
  logic [3:0]     amt_q;
  logic           reject_q;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DBW'(DEBOUNCE_CYCLES - 1)) deb_d[i] = ~deb_q[i];
        else                                       cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Simultaneous rises are an invalid coin, so only a lone rise requests a push.
  assign rise     = deb_q & ~deb_prev_q;
  assign push_req = ^rise;
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign pop      = (state_q == IDLE) && (count_q != '0) && !inhibit;
  assign push     = push_req && (!full || pop);
  assign head     = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rise[1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      gap_q      <= '0;
      amt_q      <= 4'd0;
      reject_q   <= 1'b0;
    end else begin
      sync1_q    <= {coin10_raw, coin5_raw};
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q[0]   <= cnt_d[0];
      cnt_q[1]   <= cnt_d[1];
      reject_q   <= (&rise) || (push_req && full && !pop);

      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      case (state_q)
        IDLE: begin
          amt_q <= 4'd0;
          if (pop) begin
            amt_q   <= head ? 4'd10 : 4'd5;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          amt_q   <= 4'd0;
          gap_q   <= GW'(GAP_CYCLES - 1);
          state_q <= GAP;
        end
        GAP: begin
          amt_q <= 4'd0;
          if (gap_q == '0) state_q <= IDLE;
          else             gap_q   <= gap_q - 1'b1;
        end
        default: begin
          amt_q   <= 4'd0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign amt         = amt_q;
  assign coin_reject = reject_q;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed scenarios plus randomized coin/glitch/dual-sensor
// transactions checked against a transaction-level expectation of value, latency and rejects.
module tb_coin_acceptor;
  localparam int DB    = 4;
  localparam int DEPTH = 4;
  localparam int GAP   = 1;
  localparam int LAT   = DB + 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       coin5_raw = 1'b0;
  logic       coin10_raw = 1'b0;
  logic       inhibit = 1'b0;
  logic [3:0] amt;
  logic       coin_reject;
  logic [2:0] fifo_count;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int rej_cnt = 0;
  int obs_val[$];
  int obs_cyc[$];
  logic [3:0] prev_amt = 4'd0;

  coin_acceptor #(.DEBOUNCE_CYCLES(DB), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .coin5_raw(coin5_raw), .coin10_raw(coin10_raw),
    .inhibit(inhibit), .amt(amt), .coin_reject(coin_reject), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulse monitor: records every issued coin with its cycle stamp.
  always @(negedge clk) begin
    if (reset) prev_amt <= 4'd0;
    else begin
      if (coin_reject) rej_cnt <= rej_cnt + 1;
      if (amt != 4'd0) begin
        chk("amt_legal", int'(amt == 4'd5 || amt == 4'd10), 1);
        chk("amt_spacing", int'(prev_amt), 0);
        obs_val.push_back(int'(amt));
        obs_cyc.push_back(cyc);
      end
      prev_amt <= amt;
    end
  end

  task automatic coin(input bit c5, input bit c10, input int len, output int t0);
    @(posedge clk); #1;
    coin5_raw = c5; coin10_raw = c10; t0 = cyc;
    repeat (len) @(posedge clk);
    #1; coin5_raw = 1'b0; coin10_raw = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_val.delete();
    obs_cyc.delete();
  endtask

  initial begin
    int t0, rb, kind, len, ch, k;
    int seq3[5];
    int exp6[5];
    seq3 = '{5, 10, 5, 10, 5};
    exp6 = '{5, 5, 5, 5, 10};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_amt", int'(amt), 0);
    chk("rst_reject", int'(coin_reject), 0);
    chk("rst_count", int'(fifo_count), 0);

    // 1: single 5 coin, exact latency, nothing on release
    clear_obs();
    coin(1'b1, 1'b0, 10, t0);
    idle(20);
    chk("t1_pulses", obs_val.size(), 1);
    if (obs_val.size() >= 1) begin
      chk("t1_value", obs_val[0], 5);
      chk("t1_latency", obs_cyc[0] - t0, LAT);
    end

    // 2: short glitch ignored
    clear_obs(); rb = rej_cnt;
    coin(1'b0, 1'b1, 3, t0);
    idle(20);
    chk("t2_pulses", obs_val.size(), 0);
    chk("t2_reject", rej_cnt - rb, 0);
    chk("t2_count", int'(fifo_count), 0);

    // 3: fill under inhibit, overflow reject, ordered drain
    inhibit = 1'b1; clear_obs(); rb = rej_cnt;
    for (int i = 0; i < 5; i++) begin
      coin(seq3[i] == 5, seq3[i] == 10, 8, t0);
      idle(12);
      if (i == 3) chk("t3_full_count", int'(fifo_count), 4);
    end
    chk("t3_reject", rej_cnt - rb, 1);
    chk("t3_count", int'(fifo_count), 4);
    chk("t3_no_issue", obs_val.size(), 0);
    inhibit = 1'b0;
    idle(30);
    chk("t3_pulses", obs_val.size(), 4);
    if (obs_val.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t3_order", obs_val[i], seq3[i]);
      for (int i = 0; i < 3; i++)
        chk("t3_period", int'(obs_cyc[i+1] - obs_cyc[i] >= 1 + GAP), 1);
    end
    chk("t3_drained", int'(fifo_count), 0);

    // 4: both sensors together
    clear_obs(); rb = rej_cnt;
    coin(1'b1, 1'b1, 8, t0);
    idle(20);
    chk("t4_reject", rej_cnt - rb, 1);
    chk("t4_count", int'(fifo_count), 0);
    chk("t4_pulses", obs_val.size(), 0);

    // 5: reset while amt=10 is showing, two coins still queued
    inhibit = 1'b1;
    coin(1'b0, 1'b1, 8, t0); idle(12);
    coin(1'b1, 1'b0, 8, t0); idle(12);
    coin(1'b1, 1'b0, 8, t0); idle(12);
    inhibit = 1'b0;
    k = 0;
    while (k < 40 && amt != 4'd10) begin
      @(negedge clk); k++;
    end
    chk("t5_seen10", int'(amt), 10);
    chk("t5_queued", int'(fifo_count), 2);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t5_amt", int'(amt), 0);
    chk("t5_count", int'(fifo_count), 0);
    reset = 1'b0;
    clear_obs();
    idle(30);
    chk("t5_no_issue", obs_val.size(), 0);

    // 6: full queue, pop and push land in the same cycle
    inhibit = 1'b1;
    for (int i = 0; i < 4; i++) begin
      coin(1'b1, 1'b0, 8, t0); idle(12);
    end
    chk("t6_full", int'(fifo_count), 4);
    clear_obs(); rb = rej_cnt;
    @(posedge clk); #1 coin10_raw = 1'b1;
    repeat (6) @(posedge clk);
    #1 inhibit = 1'b0;
    @(posedge clk); #1;
    chk("t6_count", int'(fifo_count), 4);
    idle(2);
    coin10_raw = 1'b0;
    chk("t6_reject", rej_cnt - rb, 0);
    idle(40);
    chk("t6_pulses", obs_val.size(), 5);
    if (obs_val.size() == 5)
      for (int i = 0; i < 5; i++) chk("t6_order", obs_val[i], exp6[i]);

    // Randomized isolated transactions
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 3);
      clear_obs(); rb = rej_cnt;
      case (kind)
        0, 1: begin
          len = $urandom_range(DB + 1, DB + 6);
          coin(kind == 0, kind == 1, len, t0);
        end
        2: begin
          len = $urandom_range(1, DB - 1);
          ch  = $urandom_range(0, 1);
          coin(ch == 0, ch == 1, len, t0);
        end
        default: coin(1'b1, 1'b1, DB + 2, t0);
      endcase
      idle(25);
      if (kind < 2) begin
        chk("rnd_pulses", obs_val.size(), 1);
        if (obs_val.size() == 1) begin
          chk("rnd_value", obs_val[0], (kind == 0) ? 5 : 10);
          chk("rnd_latency", obs_cyc[0] - t0, LAT);
        end
        chk("rnd_reject", rej_cnt - rb, 0);
      end else begin
        chk("rnd_no_pulse", obs_val.size(), 0);
        chk("rnd_reject", rej_cnt - rb, (kind == 3) ? 1 : 0);
      end
      chk("rnd_count", int'(fifo_count), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
